encapsulation_fd: RTL
=====================

# encapsulation_fd

Parametrised multi-buffer frame encapsulation for CAN/CAN FD transmission. Scans NBUF transmit buffers from IOCPU, picks the highest-priority pending frame by arbitration field, snapshots it, and presents a right-aligned header bit string, its length and the real payload byte count to tshift/tcrc. Holds the snapshot while the LLC transmits, then reports completion per buffer.

## Interface
- NBUF, 4: number of transmit buffers (2..16).
- FD_EN, 1: 1 enables FD formats; 0 forces all fdf/brs inputs to 0.
- clock  in  1  main clock, rising edge.
- reset  in  1  synchronous, active-low.
- req  in  NBUF  pending-transmit flag per buffer (IOCPU).
- id_bus  in  29*NBUF  identifier per buffer; buffer i uses bits [29i+28:29i], base ID in [28:18].
- ext, rtr, fdf, brs  in  NBUF each  per-buffer frame control.
- dlc_bus  in  4*NBUF  DLC per buffer.
- esi  in  1  error-state indicator, sampled at snapshot.
- activ  in  1  LLC transmit-start level; rising edge is the start event.
- ack  in  1  LLC frame-complete pulse.
- abort  in  1  LLC arbitration loss / error abort pulse.
- message  out  41  header bits, right-aligned, MSB first sent.
- msglen  out  6  header length in bits: 19, 22, 39 or 41.
- tmlen  out  7  real payload bytes, 0..64.
- sel  out  clog2(NBUF)  index of snapshotted buffer.
- tx_rdy  out  1  snapshot valid, awaiting activ.
- busy  out  1  frame locked for transmission.
- txdone  out  NBUF  one-cycle completion pulse, bit sel.

## Operation
- States: IDLE, SCAN, READY, LOCK.
- IDLE: req != 0 -> SCAN, index 0.
- SCAN: one buffer per cycle, index 0..NBUF-1; for req=1 buffers, key = {id[28:18], ext, ext ? id[17:0] : 18'd0, rtr & ~fdf_eff}; lowest key wins, tie -> lower index. After last index: register snapshot of winner (message, msglen, tmlen, sel, esi) -> READY. If no req set at end -> IDLE.
- READY: tx_rdy=1. req change (any bit, vs. value at SCAN end) -> SCAN (rescan). activ rising edge -> LOCK. abort -> IDLE.
- LOCK: busy=1; snapshot frozen, all buffer inputs ignored. ack -> txdone[sel]=1 for one cycle, -> IDLE. abort -> IDLE, no txdone. ack and abort same cycle: ack wins.
- activ edge detection by registered previous value; reset clears it to 0.
- Formats (fdf_eff = fdf & FD_EN; bits above msglen-1 are 0):
  - Classic base, 19: [18]SOF=0, [17:7]ID, [6]RTR, [5]IDE=0, [4]r0=0, [3:0]DLC.
  - Classic ext, 39: [38]SOF, [37:27]IDb, [26]SRR=1, [25]IDE=1, [24:7]IDx, [6]RTR, [5:4]=00, [3:0]DLC.
  - FD base, 22: [21]SOF, [20:10]ID, [9]RRS=0, [8]IDE=0, [7]FDF=1, [6]res=0, [5]BRS, [4]ESI, [3:0]DLC.
  - FD ext, 41: [40]SOF, [39:29]IDb, [28]SRR=1, [27]IDE=1, [26:9]IDx, [8]RRS=0, [7]FDF=1, [6]res=0, [5]BRS, [4]ESI, [3:0]DLC.
- FD frames: rtr ignored (RRS=0). Classic: brs/esi ignored.
- tmlen: RTR classic -> 0; DLC 0..8 -> DLC; classic 9..15 -> 8; FD 9..15 -> 12,16,20,24,32,48,64.

## Timing
- Reset: state IDLE; message, msglen, tmlen, sel, tx_rdy, busy, txdone all 0.
- req set in IDLE at cycle n: SCAN n+1..n+NBUF; tx_rdy=1 and outputs valid from n+NBUF+1.
- activ rising edge sampled at cycle m in READY: busy=1 from m+1.
- ack at cycle k in LOCK: txdone pulse at k+1, state IDLE at k+1, next SCAN no earlier than k+2.
- Outputs change only at SCAN end or reset; stable through READY and LOCK.
- Reset mid-LOCK: no txdone; all outputs 0 next cycle.

## Structure
- Shared package encaps_pkg: state encoding, header-length constants (19/22/39/41), DLC-to-length function.
- Sub-module encaps_hdr_fmt: combinational formatter, one buffer's fields -> message, msglen, tmlen; instantiated once on the scan mux output.

## Test plan
- NBUF=4, only buf2 req, ID[28:18]=0x123, ext=0, fdf=0, DLC=8 -> after 5 cycles msglen=19, message=19'b0_00100100011_0_0_0_1000, tmlen=8, sel=2.
- buf0 base 0x200, buf3 base 0x100 both req -> sel=3; rescan when buf1 req 0x050 appears in READY -> sel=1.
- FD ext, ID=29'h1ABCDEF0, brs=1, esi=1, DLC=15 -> msglen=41, [7]=1, [5]=1, [4]=1, tmlen=64; same with FD_EN=0 -> msglen=39, tmlen=8.
- Classic RTR, DLC=5 -> tmlen=0, [6]=1; FD with rtr=1 -> RRS=0, tmlen per DLC.
- READY, activ edge, then ack and abort same cycle -> txdone[sel] one-cycle pulse, IDLE.
- LOCK, change id_bus/req -> message unchanged; reset asserted -> all outputs 0, no txdone.

Source files
------------

// File: rtl/encaps_pkg.sv
// Shared types and helpers for the CAN/CAN FD frame encapsulation block.
package encaps_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_READY = 2'd2,
    ST_LOCK  = 2'd3
  } state_t;

  localparam logic [5:0] LEN_CLS_BASE = 6'd19;
  localparam logic [5:0] LEN_FD_BASE  = 6'd22;
  localparam logic [5:0] LEN_CLS_EXT  = 6'd39;
  localparam logic [5:0] LEN_FD_EXT   = 6'd41;

  // Arbitration key: base ID, IDE, extension ID, RTR; lower value wins the bus.
  localparam int KEY_W = 31;

  function automatic logic [6:0] dlc_to_len(input logic [3:0] dlc,
                                            input logic fd,
                                            input logic rtr);
    logic [6:0] len;
    if (!fd && rtr)         len = 7'd0;
    else if (dlc <= 4'd8)   len = {3'd0, dlc};
    else if (!fd)           len = 7'd8;
    else begin
      case (dlc)
        4'd9:    len = 7'd12;
        4'd10:   len = 7'd16;
        4'd11:   len = 7'd20;
        4'd12:   len = 7'd24;
        4'd13:   len = 7'd32;
        4'd14:   len = 7'd48;
        default: len = 7'd64;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/encaps_hdr_fmt.sv
// Combinational header formatter: one buffer's fields to a right-aligned
// header bit string, its length and the real payload byte count.
module encaps_hdr_fmt
  import encaps_pkg::*;
(
  input  logic [28:0] id_i,
  input  logic        ext_i,
  input  logic        rtr_i,
  input  logic        fdf_i,
  input  logic        brs_i,
  input  logic        esi_i,
  input  logic [3:0]  dlc_i,
  output logic [40:0] message_o,
  output logic [5:0]  msglen_o,
  output logic [6:0]  tmlen_o
);

  always_comb begin
    message_o = '0;
    msglen_o  = LEN_CLS_BASE;
    case ({fdf_i, ext_i})
      2'b00: begin
        message_o[18:0] = {1'b0, id_i[28:18], rtr_i, 2'b00, dlc_i};
        msglen_o        = LEN_CLS_BASE;
      end
      2'b01: begin
        message_o[38:0] = {1'b0, id_i[28:18], 2'b11, id_i[17:0], rtr_i, 2'b00, dlc_i};
        msglen_o        = LEN_CLS_EXT;
      end
      2'b10: begin
        // RRS, IDE, FDF, res ahead of BRS/ESI
        message_o[21:0] = {1'b0, id_i[28:18], 4'b0010, brs_i, esi_i, dlc_i};
        msglen_o        = LEN_FD_BASE;
      end
      default: begin
        message_o = {1'b0, id_i[28:18], 2'b11, id_i[17:0], 3'b010, brs_i, esi_i, dlc_i};
        msglen_o  = LEN_FD_EXT;
      end
    endcase
    tmlen_o = dlc_to_len(dlc_i, fdf_i, rtr_i);
  end

endmodule

// File: rtl/encapsulation_fd.sv
// Multi-buffer CAN/CAN FD encapsulation: priority scan over NBUF transmit
// buffers, snapshot of the winner's header, hold while the LLC transmits.
module encapsulation_fd
  import encaps_pkg::*;
#(
  parameter int NBUF  = 4,
  parameter bit FD_EN = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NBUF-1:0]          req,
  input  logic [29*NBUF-1:0]       id_bus,
  input  logic [NBUF-1:0]          ext,
  input  logic [NBUF-1:0]          rtr,
  input  logic [NBUF-1:0]          fdf,
  input  logic [NBUF-1:0]          brs,
  input  logic [4*NBUF-1:0]        dlc_bus,
  input  logic                     esi,
  input  logic                     activ,
  input  logic                     ack,
  input  logic                     abort,
  output logic [40:0]              message,
  output logic [5:0]               msglen,
  output logic [6:0]               tmlen,
  output logic [$clog2(NBUF)-1:0]  sel,
  output logic                     tx_rdy,
  output logic                     busy,
  output logic [NBUF-1:0]          txdone
);

  localparam int SW = $clog2(NBUF);
  localparam logic [SW-1:0] LAST_IDX = SW'(NBUF - 1);

  state_t            state_q;
  logic [SW-1:0]     idx_q, best_idx_q, win_idx_d;
  logic [KEY_W-1:0]  best_key_q, cur_key_d;
  logic              found_q, take_d, activ_q;
  logic [NBUF-1:0]   req_snap_q;

  logic [28:0]       cur_id, win_id;
  logic              cur_ext, cur_fdf, cur_rtr;
  logic              win_ext, win_rtr, win_fdf, win_brs;
  logic [3:0]        win_dlc;
  logic [40:0]       fmt_message;
  logic [5:0]        fmt_msglen;
  logic [6:0]        fmt_tmlen;

  always_comb begin
    cur_id    = id_bus[29*int'(idx_q) +: 29];
    cur_ext   = ext[idx_q];
    cur_rtr   = rtr[idx_q];
    cur_fdf   = fdf[idx_q] & FD_EN;
    cur_key_d = {cur_id[28:18], cur_ext, cur_ext ? cur_id[17:0] : 18'd0, cur_rtr & ~cur_fdf};
    // Strict less-than keeps the lower index on equal keys.
    take_d    = req[idx_q] & (~found_q | (cur_key_d < best_key_q));
    win_idx_d = take_d ? idx_q : best_idx_q;
    win_id    = id_bus[29*int'(win_idx_d) +: 29];
    win_ext   = ext[win_idx_d];
    win_rtr   = rtr[win_idx_d];
    win_fdf   = fdf[win_idx_d] & FD_EN;
    win_brs   = brs[win_idx_d] & FD_EN;
    win_dlc   = dlc_bus[4*int'(win_idx_d) +: 4];
  end

  encaps_hdr_fmt u_fmt (
    .id_i      (win_id),
    .ext_i     (win_ext),
    .rtr_i     (win_rtr),
    .fdf_i     (win_fdf),
    .brs_i     (win_brs),
    .esi_i     (esi),
    .dlc_i     (win_dlc),
    .message_o (fmt_message),
    .msglen_o  (fmt_msglen),
    .tmlen_o   (fmt_tmlen)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_key_q <= '0;
      found_q    <= 1'b0;
      req_snap_q <= '0;
      activ_q    <= 1'b0;
      message    <= '0;
      msglen     <= '0;
      tmlen      <= '0;
      sel        <= '0;
      tx_rdy     <= 1'b0;
      busy       <= 1'b0;
      txdone     <= '0;
    end else begin
      activ_q <= activ;
      txdone  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            state_q <= ST_SCAN;
            idx_q   <= '0;
            found_q <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (take_d) begin
            best_key_q <= cur_key_d;
            best_idx_q <= idx_q;
            found_q    <= 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            if (found_q || req[idx_q]) begin
              message    <= fmt_message;
              msglen     <= fmt_msglen;
              tmlen      <= fmt_tmlen;
              sel        <= win_idx_d;
              req_snap_q <= req;
              tx_rdy     <= 1'b1;
              state_q    <= ST_READY;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_READY: begin
          if (abort) begin
            tx_rdy  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (activ && !activ_q) begin
            tx_rdy  <= 1'b0;
            busy    <= 1'b1;
            state_q <= ST_LOCK;
          end else if (req != req_snap_q) begin
            tx_rdy  <= 1'b0;
            idx_q   <= '0;
            found_q <= 1'b0;
            state_q <= ST_SCAN;
          end
        end
        default: begin
          // ack takes precedence over a simultaneous abort
          if (ack) begin
            txdone[sel] <= 1'b1;
            busy        <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (abort) begin
            busy    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
